enigma_char_sequencer: RTL
==========================

// Module: enigma_char_sequencer
// PURPOSE
//  Front-end stage that feeds the forward rotor path and collects the cipher core's 5-bit result.
//  Accepts an ASCII byte stream over a valid/ready handshake and maps A-Z/a-z to letter codes 0..25.
//  For each letter it issues one rotor-step pulse, drives the code into the core and waits a fixed settle time.
//  It then captures the core result and returns uppercase ASCII ciphertext over a second valid/ready handshake.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles between step pulse and result capture; legal range 1..15
//  PASS_NONALPHA  1  1: pass non-letters through unchanged (no step); 0: drop them silently
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  rst            in   1   synchronous, active-high reset
//  in_byte        in   8   plaintext ASCII byte
//  in_valid       in   1   in_byte valid
//  in_ready       out  1   sequencer can accept a byte
//  core_data_in   out  5   letter code driven into the rotor path (data_in of forward stage)
//  core_step      out  1   one-cycle pulse that advances the rotation engine
//  core_data_out  in   5   cipher core result code for core_data_in
//  out_byte       out  8   ciphertext ASCII byte
//  out_valid      out  1   out_byte valid
//  out_ready      in   1   downstream accepts out_byte
//  char_count     out  16  letters enciphered since reset; wraps 0xFFFF->0
//  err_count      out  8   core results >25 since reset; saturates at 0xFF
// BEHAVIOUR
//  Clock and reset:
//   - one clock; reset is synchronous and active-high.
//   - Reset forces state=IDLE, in_ready=1, out_valid=0, out_byte=0, core_data_in=0.
//   - Reset also forces core_step=0, char_count=0, err_count=0.
//   - Reset mid-operation aborts the character: no out_valid, no count update.
//  FSM states: IDLE, STEP, SETTLE, CAPTURE, EMIT.
//  IDLE:
//   - in_ready=1 only in IDLE; the byte is accepted on an edge with in_valid&in_ready.
//   - 0x41..0x5A: code=byte-0x41. 0x61..0x7A: code=byte-0x61. Either goes to STEP.
//   - Other byte with PASS_NONALPHA=1: out_byte<=byte, go to EMIT.
//   - Other byte with PASS_NONALPHA=0: dropped, stay in IDLE.
//  STEP (1 cycle):
//   - core_step=1, core_data_in=code; then SETTLE.
//   - core_step is high in no other state.
//  SETTLE:
//   - A 4-bit counter runs SETTLE_CYCLES cycles, then CAPTURE.
//   - core_data_in is held stable from STEP through CAPTURE.
//  CAPTURE (1 cycle):
//   - If core_data_out<=25: out_byte<=0x41+core_data_out.
//   - Else: out_byte<=0x3F ('?') and err_count+1 (saturating).
//   - char_count+1 in both cases; then EMIT.
//  EMIT:
//   - out_valid=1; out_byte is stable while out_valid=1 and out_ready=0.
//   - On out_valid&out_ready: out_valid<=0, return to IDLE (next byte accepted the following cycle).
//  Latency (accept edge = cycle 0):
//   - Letter: step pulse in cycle 1, out_valid from cycle 3+SETTLE_CYCLES (5 at default).
//   - Passthrough: out_valid from cycle 1.
//   - Throughput with out_ready=1: one letter per 4+SETTLE_CYCLES cycles.
//  Other rules:
//   - No internal buffering: exactly one character in flight.
//   - in_valid while busy is not consumed.
//   - A byte presented during the out_valid&out_ready cycle is not accepted until the next IDLE cycle.
//   - The rotor path sees exactly one core_step per accepted letter and none for passthrough or dropped bytes.
// TESTING
//  1 'A' (0x41), core model returns 13 -> core_data_in=0, one core_step in cycle 1, out_byte=0x4E at cycle 5, char_count=1.
//  2 'z' (0x7A) -> core_data_in=25, one step; core returns 0 -> out_byte=0x41.
//  3 ' ' (0x20), PASS_NONALPHA=1 -> out_byte=0x20, out_valid at cycle 1, no core_step, char_count unchanged.
//    Same stimulus with PASS_NONALPHA=0 -> no out_valid, in_ready stays 1.
//  4 'HELLO' with out_ready low 10 cycles on 'E' -> out_byte held, in_ready=0 throughout.
//    Exactly 5 step pulses, char_count=5.
//  5 Core returns 30 -> out_byte=0x3F, err_count=1.
//    Force err_count to 0xFF, repeat -> err_count stays 0xFF.
//  6 rst asserted during SETTLE -> next cycle IDLE, in_ready=1, out_valid=0, counts=0, no step pulse follows.

Source files
------------

// File: rtl/enigma_char_sequencer.sv
// Byte-stream front end for the rotor cipher core: maps letters to codes, steps the rotors,
// waits for the core to settle and returns uppercase ciphertext; non-letters pass through or drop.
//
// state   | meaning
// IDLE    | ready for a new byte
// STEP    | one-cycle rotor step pulse, letter code on core_data_in
// SETTLE  | wait SETTLE_CYCLES for the core result
// CAPTURE | latch core result into out_byte, update counters
// EMIT    | out_valid high until downstream takes the byte
module enigma_char_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          PASS_NONALPHA = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [4:0]  core_data_in,
    output logic        core_step,
    input  logic [4:0]  core_data_out,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] char_count,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        SETTLE,
        CAPTURE,
        EMIT
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] settle_cnt;
    logic       is_upper;
    logic       is_lower;
    logic       is_alpha;
    logic       accept;

    assign is_upper = (in_byte >= 8'h41) && (in_byte <= 8'h5A);
    assign is_lower = (in_byte >= 8'h61) && (in_byte <= 8'h7A);
    assign is_alpha = is_upper || is_lower;
    assign accept   = (state == IDLE) && in_valid;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        core_step = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_alpha)
                        state_nx = STEP;
                    else if (PASS_NONALPHA)
                        state_nx = EMIT;
                end
            end
            STEP: begin
                core_step = 1'b1;
                state_nx  = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == 4'd0)
                    state_nx = CAPTURE;
            end
            CAPTURE: state_nx = EMIT;
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            settle_cnt   <= 4'd0;
            core_data_in <= 5'd0;
            out_byte     <= 8'h00;
            char_count   <= 16'd0;
            err_count    <= 8'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                // 'A' and 'a' both have low five bits 1, so one subtract covers both cases
                if (is_alpha)
                    core_data_in <= in_byte[4:0] - 5'd1;
                else if (PASS_NONALPHA)
                    out_byte <= in_byte;
            end
            if (state == STEP)
                settle_cnt <= SETTLE_LOAD;
            else if ((state == SETTLE) && (settle_cnt != 4'd0))
                settle_cnt <= settle_cnt - 4'd1;
            if (state == CAPTURE) begin
                char_count <= char_count + 16'd1;
                if (core_data_out <= 5'd25) begin
                    out_byte <= 8'h41 + {3'b000, core_data_out};
                end else begin
                    out_byte <= 8'h3F;
                    if (err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule
